mem_stage: RTL and testbench
============================

# mem_stage

Parametrised memory-access pipeline stage between execute and write-back. Drives a single-master AHB-Lite-style bus with proper address/data phases and HREADY wait states. Supports byte, halfword, word and doubleword accesses with byte-lane steering and load sign/zero extension. Non-memory instructions pass their ALU result through in one cycle.

## Interface
- XLEN, 64, data width; legal values 32 and 64.
- ADDR_W, 64, address width.
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- EN  in  1  current instruction is a memory access.
- LOAD  in  1  1 = load, 0 = store; meaningful only when EN=1.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- unsigned_ld  in  1  zero-extend the load result instead of sign-extending it.
- address  in  ADDR_W  effective address.
- value  in  XLEN  store data, right-aligned.
- alu_res  in  XLEN  pass-through result.
- rd_i  in  5  destination register.
- write_back  in  1  instruction writes rd.
- stall  in  1  upstream bubble request.
- HRDATA  in  XLEN  bus read data.
- HREADY  in  1  bus phase completion.
- HADDR  out  ADDR_W  bus address.
- HWDATA  out  XLEN  bus write data, lane-steered.
- HWRITE  out  1  bus direction.
- HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- HSIZE  out  3  {1'b0, size}.
- res  out  XLEN  result to write-back.
- rd_o  out  5  registered rd.
- mem_write_back_en  out  1  write-back valid.
- busy  out  1  stage is occupied; upstream must hold all inputs stable while high.
- misalign  out  1  one-cycle pulse; present only with MEM_STAGE_MISALIGN_TRAP_EN.

## Operation
- States: IDLE, ADDR, DATA. `busy` = (state != IDLE), combinational from the state register.
- IDLE, stall=1: no acceptance. Registers res=0, rd_o=0, mem_write_back_en=0, HTRANS=IDLE.
- IDLE, stall=0, EN=0: registers res=alu_res, rd_o=rd_i, mem_write_back_en=write_back. State stays IDLE.
- IDLE, stall=0, EN=1: registers HADDR=address, HWRITE=~LOAD, HSIZE, HTRANS=NONSEQ. Latches the op (rd, write_back, size, unsigned_ld, offset, value) and moves to ADDR. res, rd_o and mem_write_back_en register 0 (bubble).
- ADDR: held until HREADY=1. On HREADY, HTRANS goes IDLE and the state moves to DATA. For a store, HWDATA = value << (8*offset), where offset = address[log2(XLEN/8)-1:0].
- DATA: held until HREADY=1. On HREADY:
  - Load: res = extend((HRDATA >> 8*offset), size, unsigned_ld).
  - Store: res = 0.
  - In both cases rd_o and mem_write_back_en take the latched values; the state returns to IDLE.
- While busy, res, rd_o and mem_write_back_en hold 0 and stall is ignored. A started bus transfer is never aborted.
- XLEN=32 with size=3 is illegal: treated as misaligned, see Configuration.
- Reset (RST_N=0 at an edge): state=IDLE, HTRANS=IDLE. HADDR, HWDATA, HWRITE, HSIZE, res, rd_o, mem_write_back_en, misalign all reset to 0. Reset in ADDR or DATA abandons the transfer.

## Timing
- Pass-through op: 1-cycle latency.
- Memory op accepted at edge N: NONSEQ visible in cycle N+1. With zero wait states, the result and write-back pulse are visible in cycle N+3; each HREADY=0 cycle adds one.
- busy is high from cycle N+1 through the cycle the DATA phase completes.
- mem_write_back_en is a single-cycle pulse per instruction.
- Back-to-back memory ops: the next op is accepted in the first IDLE cycle. No address/data-phase overlap (no pipelined bursts).

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - An access with address not aligned to 2^size, or the illegal size, is not issued.
  - misalign pulses 1 for one cycle at the accept edge; res=0, mem_write_back_en=0; state stays IDLE.
- Undefined: no misalign port. Accesses are issued unchanged and alignment is the bus's responsibility.

## Structure
- Shared package mem_stage_pkg holds:
  - HTRANS codes.
  - Size encodings.
  - State enum.
  - The extend function.
- Natural sub-module: mem_lane_align (combinational store shift and load shift+extend), instantiated once for each direction.

## Test plan
- Pass-through: EN=0, alu_res=64'h1234, rd_i=5, write_back=1 -> next cycle res=64'h1234, rd_o=5, wb_en=1.
- Signed byte load: address=...3, HRDATA=64'h00000000_80000000, size=0, unsigned_ld=0, zero waits -> res=64'hFFFF_FFFF_FFFF_FF80 at N+3.
- Halfword store: address=...6, value=16'hBEEF, two HREADY=0 cycles in DATA -> HWDATA=64'hBEEF_0000_0000_0000; busy high 4 cycles.
- Stall: stall=1 in IDLE with EN=1 -> no NONSEQ, wb_en=0. Stall asserted during DATA -> transfer still completes.
- Reset mid-DATA: RST_N=0 -> next cycle HTRANS=0, busy=0, wb_en=0.
- With the macro, word load at address=...2 -> misalign=1 for one cycle, HTRANS stays IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings, op payload and load-extension helper for the memory stage.
package mem_stage_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  // Op attributes latched at accept and consumed when the data phase retires
  typedef struct packed {
    logic [4:0] rd;
    logic       wb;
    logic [1:0] size;
    logic       uns;
  } mem_op_t;

  // Sign- or zero-extend the low 2^sz bytes of d to 64 bits
  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic uns);
    logic [63:0] r;
    case (sz)
      SZ_BYTE:  r = uns ? {56'b0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      SZ_HALF:  r = uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_WORD:  r = uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default:  r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// AHB-Lite-style single-master bus between the memory stage and memory.
interface mem_stage_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) ();
  logic [ADDR_W-1:0] HADDR;
  logic [XLEN-1:0]   HWDATA;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [XLEN-1:0]   HRDATA;
  logic              HREADY;

  modport master (output HADDR, HWDATA, HWRITE, HTRANS, HSIZE,
                  input  HRDATA, HREADY);
  modport slave  (input  HADDR, HWDATA, HWRITE, HTRANS, HSIZE,
                  output HRDATA, HREADY);
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data shifted up into its lane, or load data
// shifted down from its lane and extended to XLEN.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                        load_i,
  input  logic [XLEN-1:0]             data_i,
  input  logic [$clog2(XLEN/8)-1:0]   offset_i,
  input  logic [1:0]                  size_i,
  input  logic                        unsigned_i,
  output logic [XLEN-1:0]             data_c
);
  logic [$clog2(XLEN/8)+2:0] sh;

  // Shift by whole bytes; loads additionally extend from the access size
  always_comb begin
    sh = {offset_i, 3'b000};
    if (load_i) data_c = XLEN'(extend(64'(data_i >> sh), size_i, unsigned_i));
    else        data_c = data_i << sh;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: pass-through for ALU ops, one non-pipelined
// AHB-Lite transfer (address phase, then data phase) for loads and stores.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN (misaligned/illegal
// accesses are dropped and flagged on the misalign port).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              LOAD,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [XLEN-1:0]   value,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [4:0]        rd_i,
  input  logic              write_back,
  input  logic              stall,
  mem_stage_if.master       bus,
  output logic [XLEN-1:0]   res,
  output logic [4:0]        rd_o,
  output logic              mem_write_back_en,
  output logic              busy
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  , output logic            misalign
`endif
);
  localparam int unsigned OFF_W = $clog2(XLEN/8);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [XLEN-1:0]   hwdata_q, hwdata_d;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_q, wb_d;
  mem_op_t           op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [XLEN-1:0]   val_q, val_d;
  logic [XLEN-1:0]   st_data_c, ld_data_c;
  logic              mis_c;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
`endif

  mem_lane_align #(.XLEN(XLEN)) u_store_align (
    .load_i(1'b0), .data_i(val_q), .offset_i(off_q),
    .size_i(op_q.size), .unsigned_i(op_q.uns), .data_c(st_data_c)
  );

  mem_lane_align #(.XLEN(XLEN)) u_load_align (
    .load_i(1'b1), .data_i(bus.HRDATA), .offset_i(off_q),
    .size_i(op_q.size), .unsigned_i(op_q.uns), .data_c(ld_data_c)
  );

  // Alignment check on the incoming access (never trips when trapping is off)
  always_comb begin
    mis_c = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    case (size)
      SZ_HALF:  mis_c = address[0];
      SZ_WORD:  mis_c = |address[1:0];
      SZ_DWORD: mis_c = (XLEN == 32) || (|address[2:0]);
      default:  mis_c = 1'b0;
    endcase
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    htrans_d = htrans_q;
    hsize_d  = hsize_q;
    op_d     = op_q;
    off_d    = off_q;
    val_d    = val_q;
    res_d    = '0;
    rd_d     = '0;
    wb_d     = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        htrans_d = HTRANS_IDLE;
        if (!stall) begin
          if (!EN) begin
            res_d = alu_res;
            rd_d  = rd_i;
            wb_d  = write_back;
          end else if (mis_c) begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
          end else begin
            haddr_d  = address;
            hwrite_d = ~LOAD;
            hsize_d  = {1'b0, size};
            htrans_d = HTRANS_NONSEQ;
            op_d     = '{rd: rd_i, wb: write_back, size: size, uns: unsigned_ld};
            off_d    = address[OFF_W-1:0];
            val_d    = value;
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) hwdata_d = st_data_c;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.HREADY) begin
          res_d   = hwrite_q ? '0 : ld_data_c;
          rd_d    = op_q.rd;
          wb_d    = op_q.wb;
          state_d = ST_IDLE;
        end
      end
      default: begin
        htrans_d = HTRANS_IDLE;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hsize_q  <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      op_q     <= '0;
      off_q    <= '0;
      val_q    <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      hsize_q  <= hsize_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      op_q     <= op_d;
      off_q    <= off_d;
      val_q    <= val_d;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign bus.HADDR         = haddr_q;
  assign bus.HWDATA        = hwdata_q;
  assign bus.HWRITE        = hwrite_q;
  assign bus.HTRANS        = htrans_q;
  assign bus.HSIZE         = hsize_q;
  assign res               = res_q;
  assign rd_o              = rd_q;
  assign mem_write_back_en = wb_q;
  assign busy              = (state_q != ST_IDLE);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign          = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-level model.
module tb_mem_stage;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 64;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              EN, LOAD, unsigned_ld, write_back, stall;
  logic [1:0]        size;
  logic [ADDR_W-1:0] address;
  logic [XLEN-1:0]   value, alu_res;
  logic [4:0]        rd_i;
  logic [XLEN-1:0]   res;
  logic [4:0]        rd_o;
  logic              mem_write_back_en, busy;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mem_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  mem_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .value(value),
    .alu_res(alu_res), .rd_i(rd_i), .write_back(write_back), .stall(stall),
    .bus(bus), .res(res), .rd_o(rd_o), .mem_write_back_en(mem_write_back_en),
    .busy(busy)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Store lane model: byte i of the bus word is data byte (i - offset)
  function automatic logic [63:0] model_store(input logic [63:0] v, input int off);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) r[8*i +: 8] = v[8*(i-off) +: 8];
    return r;
  endfunction

  // Load model: gather 2^sz bytes starting at offset, then extend
  function automatic logic [63:0] model_load(input logic [63:0] d, input int sz,
                                             input int off, input bit uns);
    logic [63:0] r = '0;
    int nb = 1 << sz;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) r[8*i +: 8] = d[8*(off+i) +: 8];
    if (!uns && r[8*nb-1])
      for (int b = 8*nb; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  task automatic park();
    EN = 1'b0; stall = 1'b1;
  endtask

  // One complete memory transfer with aw/dw wait states in address/data phase
  task automatic mem_op(input bit ld, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] val,
                        input logic [63:0] rdata, input int aw, input int dw,
                        input bit stl);
    logic [4:0] rd = 5'($urandom);
    bit         wb = 1'($urandom);
    int         off = int'(addr[2:0]);
    int         busy_cnt = 0;
    EN = 1'b1; LOAD = ld; size = sz; unsigned_ld = uns; address = addr;
    value = val; rd_i = rd; write_back = wb; stall = 1'b0;
    alu_res = {$urandom, $urandom};
    check("busy_pre", 64'(busy), 64'd0);
    @(negedge CLK);
    busy_cnt += int'(busy);
    check("htrans_nonseq", 64'(bus.HTRANS), 64'd2);
    check("haddr", bus.HADDR, addr);
    check("hwrite", 64'(bus.HWRITE), 64'(!ld));
    check("hsize", 64'(bus.HSIZE), 64'(sz));
    check("wb_addr", 64'(mem_write_back_en), 64'd0);
    stall = stl;
    for (int i = 0; i < aw; i++) begin
      bus.HREADY = 1'b0; bus.HRDATA = {$urandom, $urandom};
      @(negedge CLK);
      busy_cnt += int'(busy);
      check("htrans_hold", 64'(bus.HTRANS), 64'd2);
    end
    bus.HREADY = 1'b1;
    @(negedge CLK);
    busy_cnt += int'(busy);
    check("htrans_data", 64'(bus.HTRANS), 64'd0);
    if (!ld) check("hwdata", bus.HWDATA, model_store(val, off));
    for (int i = 0; i < dw; i++) begin
      bus.HREADY = 1'b0; bus.HRDATA = {$urandom, $urandom};
      @(negedge CLK);
      busy_cnt += int'(busy);
      check("wb_wait", 64'(mem_write_back_en), 64'd0);
    end
    bus.HREADY = 1'b1; bus.HRDATA = rdata;
    @(negedge CLK);
    bus.HRDATA = {$urandom, $urandom};
    check("res", res, ld ? model_load(rdata, int'(sz), off, uns) : 64'd0);
    check("rd_o", 64'(rd_o), 64'(rd));
    check("wb_pulse", 64'(mem_write_back_en), 64'(wb));
    check("busy_post", 64'(busy), 64'd0);
    check("busy_cycles", 64'(busy_cnt), 64'(aw + dw + 2));
    park();
    @(negedge CLK);
    check("wb_single", 64'(mem_write_back_en), 64'd0);
  endtask

  task automatic pass_op(input logic [63:0] alu, input logic [4:0] rd, input bit wb);
    EN = 1'b0; stall = 1'b0; LOAD = 1'($urandom); alu_res = alu; rd_i = rd;
    write_back = wb;
    @(negedge CLK);
    check("pt_res", res, alu);
    check("pt_rd", 64'(rd_o), 64'(rd));
    check("pt_wb", 64'(mem_write_back_en), 64'(wb));
    check("pt_htrans", 64'(bus.HTRANS), 64'd0);
    park();
  endtask

  task automatic stall_op();
    EN = 1'b1; stall = 1'b1; LOAD = 1'($urandom); write_back = 1'b1;
    address = {$urandom, $urandom}; size = 2'd0; alu_res = {$urandom, $urandom};
    @(negedge CLK);
    check("stall_htrans", 64'(bus.HTRANS), 64'd0);
    check("stall_wb", 64'(mem_write_back_en), 64'd0);
    check("stall_res", res, 64'd0);
    check("stall_busy", 64'(busy), 64'd0);
    park();
  endtask

  initial begin
    logic [63:0] a, m;
    logic [1:0]  sz;
    RST_N = 1'b0; EN = 1'b0; LOAD = 1'b0; size = '0; unsigned_ld = 1'b0;
    address = '0; value = '0; alu_res = '0; rd_i = '0; write_back = 1'b0;
    stall = 1'b0; bus.HREADY = 1'b1; bus.HRDATA = '0;
    repeat (2) @(negedge CLK);
    check("rst_htrans", 64'(bus.HTRANS), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res", res, 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);
    check("rst_wb", 64'(mem_write_back_en), 64'd0);
    check("rst_haddr", bus.HADDR, 64'd0);
    check("rst_hwdata", bus.HWDATA, 64'd0);
    RST_N = 1'b1;
    park();
    @(negedge CLK);

    pass_op(64'h1234, 5'd5, 1'b1);
    mem_op(1'b1, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0, 1'b0);
    mem_op(1'b0, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 64'h0, 0, 2, 1'b0);
    stall_op();
    mem_op(1'b1, 2'd2, 1'b1, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 1, 1, 1'b1);

    // Reset during the data phase abandons the transfer
    EN = 1'b1; LOAD = 1'b1; size = 2'd2; address = 64'h40; stall = 1'b0;
    @(negedge CLK);
    park();
    @(negedge CLK);
    bus.HREADY = 1'b0; RST_N = 1'b0;
    @(negedge CLK);
    check("rstmid_htrans", 64'(bus.HTRANS), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_wb", 64'(mem_write_back_en), 64'd0);
    RST_N = 1'b1; bus.HREADY = 1'b1;
    @(negedge CLK);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    EN = 1'b1; LOAD = 1'b1; size = 2'd2; address = 64'h1002; stall = 1'b0;
    write_back = 1'b1;
    @(negedge CLK);
    check("mis_pulse", 64'(misalign), 64'd1);
    check("mis_htrans", 64'(bus.HTRANS), 64'd0);
    check("mis_busy", 64'(busy), 64'd0);
    check("mis_wb", 64'(mem_write_back_en), 64'd0);
    park();
    @(negedge CLK);
    check("mis_clear", 64'(misalign), 64'd0);
`endif

    for (int it = 0; it < 60; it++) begin
      int kind = int'($urandom_range(0, 5));
      if (kind <= 3) begin
        sz = 2'($urandom);
        a  = {$urandom, $urandom};
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        m = 64'(1) << sz;
        a = a & ~(m - 64'd1);
`else
        m = '0;
`endif
        mem_op(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
               {$urandom, $urandom}, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 1'($urandom));
      end else if (kind == 4) begin
        pass_op({$urandom, $urandom}, 5'($urandom), 1'($urandom));
      end else begin
        stall_op();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
